// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the multi-port register file.
// Optional feature macro used by this slice: REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [DATA_W_DEF-1:0] word_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

  // A write (or issue) only counts when enabled and not aimed at a hard-wired zero register.
  function automatic logic eff_write(input logic en, input logic [31:0] addr, input logic zero_reg);
    return en & ~(zero_reg & (addr == 32'd0));
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by issue, cleared by effective write-back.
// An issue and a write-back to the same register in one cycle leave the bit set,
// because the newly issued instruction is the producer that must still complete.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     wr_en0,
  input  logic [ADDR_W-1:0]        wr_addr0,
  input  logic                     wr_en1,
  input  logic [ADDR_W-1:0]        wr_addr1,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_mask,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_r;
  logic [DEPTH-1:0] busy_next_s;
  logic             issue_eff_s;

  // Qualify the issue request (issue to a hard-wired zero register is dropped).
  always_comb begin
    issue_eff_s = eff_write(issue_valid, 32'(issue_addr), ZERO_REG != 32'sd0);
  end

  // Next busy vector: set has priority over clear for the same register.
  always_comb begin
    busy_next_s = busy_r;
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_eff_s && (issue_addr == ADDR_W'(i))) begin
        busy_next_s[i] = 1'b1;
      end else if ((wr_en0 && (wr_addr0 == ADDR_W'(i))) || (wr_en1 && (wr_addr1 == ADDR_W'(i)))) begin
        busy_next_s[i] = 1'b0;
      end else begin
        busy_next_s[i] = busy_r[i];
      end
    end
  end

  // Busy bit storage with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= {DEPTH{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  // Busy lookup per read port; a bypassed read sees its producer completing now.
  always_comb begin
    rd_busy = {NUM_RD{1'b0}};
    for (int p = 0; p < NUM_RD; p++) begin
      rd_busy[p] = busy_r[rd_addr[p*ADDR_W +: ADDR_W]] & ~rd_mask[p];
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file: NUM_RD combinational read ports, two write-back
// ports (port 1 wins on an address clash) and a busy scoreboard.
// Optional macro REGFILE_BYPASS_EN: same-cycle write data is forwarded to reads.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk_Regs,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] R_Addr,
  output logic [NUM_RD*DATA_W-1:0] R_Data,
  output logic [NUM_RD-1:0]        R_Busy,
  input  logic                     Reg_Write0,
  input  logic [ADDR_W-1:0]        W_Addr0,
  input  logic [DATA_W-1:0]        W_Data0,
  input  logic                     Reg_Write1,
  input  logic [ADDR_W-1:0]        W_Addr1,
  input  logic [DATA_W-1:0]        W_Data1,
  input  logic                     Issue_Valid,
  input  logic [ADDR_W-1:0]        Issue_Addr,
  output logic                     Wr_Conflict
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]        mem_r [DEPTH];
  logic                     conflict_r;
  logic                     we0_s;
  logic                     we1_s;
  logic [NUM_RD*DATA_W-1:0] rd_data_s;
  logic [NUM_RD-1:0]        hit_s;

  // Effective write qualifiers for both write-back ports.
  always_comb begin
    we0_s = eff_write(Reg_Write0, 32'(W_Addr0), ZERO_REG != 32'sd0);
    we1_s = eff_write(Reg_Write1, 32'(W_Addr1), ZERO_REG != 32'sd0);
  end

  // Register array and clash flag; port 1 is applied last so it wins on a clash.
  always_ff @(posedge clk_Regs or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
      conflict_r <= 1'b0;
    end else begin
      if (we0_s) begin
        mem_r[W_Addr0] <= W_Data0;
      end
      if (we1_s) begin
        mem_r[W_Addr1] <= W_Data1;
      end
      conflict_r <= we0_s & we1_s & (W_Addr0 == W_Addr1);
    end
  end

  // Read ports: zero register first, then optional forwarding, else stored data.
  // Forwarding is suppressed during reset so every read is zero while rst is held.
  always_comb begin
    rd_data_s = {(NUM_RD*DATA_W){1'b0}};
    hit_s     = {NUM_RD{1'b0}};
    for (int p = 0; p < NUM_RD; p++) begin
      if ((ZERO_REG != 32'sd0) && (R_Addr[p*ADDR_W +: ADDR_W] == {ADDR_W{1'b0}})) begin
        rd_data_s[p*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        hit_s[p]                      = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (!rst && we1_s && (W_Addr1 == R_Addr[p*ADDR_W +: ADDR_W])) begin
        rd_data_s[p*DATA_W +: DATA_W] = W_Data1;
        hit_s[p]                      = 1'b1;
      end else if (!rst && we0_s && (W_Addr0 == R_Addr[p*ADDR_W +: ADDR_W])) begin
        rd_data_s[p*DATA_W +: DATA_W] = W_Data0;
        hit_s[p]                      = 1'b1;
      end
`endif
      else begin
        rd_data_s[p*DATA_W +: DATA_W] = mem_r[R_Addr[p*ADDR_W +: ADDR_W]];
        hit_s[p]                      = 1'b0;
      end
    end
  end

  assign R_Data      = rd_data_s;
  assign Wr_Conflict = conflict_r;

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk        (clk_Regs),
    .rst        (rst),
    .issue_valid(Issue_Valid),
    .issue_addr (Issue_Addr),
    .wr_en0     (we0_s),
    .wr_addr0   (W_Addr0),
    .wr_en1     (we1_s),
    .wr_addr1   (W_Addr1),
    .rd_addr    (R_Addr),
    .rd_mask    (hit_s),
    .rd_busy    (R_Busy)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: default configuration driven by directed
// and random stimulus against an array model, plus a wide/shallow variant.
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic clk_Regs = 1'b0;
  always #5 clk_Regs = ~clk_Regs;

  logic             rst;
  logic [NR*AW-1:0] R_Addr;
  logic [NR*DW-1:0] R_Data;
  logic [NR-1:0]    R_Busy;
  logic             Reg_Write0, Reg_Write1, Issue_Valid, Wr_Conflict;
  logic [AW-1:0]    W_Addr0, W_Addr1, Issue_Addr;
  logic [DW-1:0]    W_Data0, W_Data1;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk_Regs(clk_Regs), .rst(rst), .R_Addr(R_Addr), .R_Data(R_Data), .R_Busy(R_Busy),
    .Reg_Write0(Reg_Write0), .W_Addr0(W_Addr0), .W_Data0(W_Data0),
    .Reg_Write1(Reg_Write1), .W_Addr1(W_Addr1), .W_Data1(W_Data1),
    .Issue_Valid(Issue_Valid), .Issue_Addr(Issue_Addr), .Wr_Conflict(Wr_Conflict)
  );

  // Wide/shallow variant: 64-bit, 8 registers, 4 read ports, r0 writable.
  logic [4*3-1:0]  s_raddr;
  logic [4*64-1:0] s_rdata;
  logic [3:0]      s_rbusy;
  logic            s_we0, s_we1, s_iv, s_conf;
  logic [2:0]      s_a0, s_a1, s_ia;
  logic [63:0]     s_d0, s_d1;

  reg_file_mp #(.DATA_W(64), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0)) dut2 (
    .clk_Regs(clk_Regs), .rst(rst), .R_Addr(s_raddr), .R_Data(s_rdata), .R_Busy(s_rbusy),
    .Reg_Write0(s_we0), .W_Addr0(s_a0), .W_Data0(s_d0),
    .Reg_Write1(s_we1), .W_Addr1(s_a1), .W_Data1(s_d1),
    .Issue_Valid(s_iv), .Issue_Addr(s_ia), .Wr_Conflict(s_conf)
  );

  typedef struct {
    logic [NR*DW-1:0] data;
    logic [NR-1:0]    busy;
    logic             conf;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: register contents, busy bits, conflict flag seen this cycle.
  logic [DW-1:0] m_reg [DEPTH];
  bit            m_busy [DEPTH];
  bit            m_conf;

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_conf = 1'b0;
  endtask

  // Apply the inputs that were held across the clock edge that just occurred.
  task automatic commit();
    bit e0, e1;
    if (rst) begin
      clear_model();
    end else begin
      e0 = Reg_Write0 && (W_Addr0 != 0);
      e1 = Reg_Write1 && (W_Addr1 != 0);
      m_conf = e0 && e1 && (W_Addr0 == W_Addr1);
      if (e0) m_reg[W_Addr0] = W_Data0;
      if (e1) m_reg[W_Addr1] = W_Data1;
      if (e0) m_busy[W_Addr0] = 1'b0;
      if (e1) m_busy[W_Addr1] = 1'b0;
      if (Issue_Valid && (Issue_Addr != 0)) m_busy[Issue_Addr] = 1'b1;
    end
  endtask

  // One cycle of stimulus; the expected outputs for this cycle go to the queue.
  task automatic step(input bit r, input bit w0, input int a0, input logic [31:0] d0,
                      input bit w1, input int a1, input logic [31:0] d1,
                      input bit iv, input int ia, input int ra0, input int ra1);
    exp_t e;
    int   ra [NR];
    bit   e0, e1;
    @(posedge clk_Regs);
    #1;
    commit();
    rst = r;
    Reg_Write0 = w0; W_Addr0 = AW'(a0); W_Data0 = d0;
    Reg_Write1 = w1; W_Addr1 = AW'(a1); W_Data1 = d1;
    Issue_Valid = iv; Issue_Addr = AW'(ia);
    R_Addr = {AW'(ra1), AW'(ra0)};
    if (r) clear_model();
    ra[0] = ra0;
    ra[1] = ra1;
    e0 = w0 && (a0 != 0);
    e1 = w1 && (a1 != 0);
    e.conf = m_conf;
    e.data = '0;
    e.busy = '0;
    for (int p = 0; p < NR; p++) begin
      if (r || ra[p] == 0) begin
        e.data[p*DW +: DW] = '0;
        e.busy[p] = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (e1 && a1 == ra[p]) begin
        e.data[p*DW +: DW] = d1;
        e.busy[p] = 1'b0;
      end else if (e0 && a0 == ra[p]) begin
        e.data[p*DW +: DW] = d0;
        e.busy[p] = 1'b0;
      end
`endif
      else begin
        e.data[p*DW +: DW] = m_reg[ra[p]];
        e.busy[p] = m_busy[ra[p]];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int ra0, input int ra1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, ra0, ra1);
  endtask

  // Monitor: mid-cycle, compare the DUT outputs against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_Regs);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int p = 0; p < NR; p++) begin
          n_tests++;
          if (R_Data[p*DW +: DW] !== e.data[p*DW +: DW]) begin
            n_fail++;
            $display("FAIL rdata port%0d addr %0d: got %h expected %h at %0t",
                     p, R_Addr[p*AW +: AW], R_Data[p*DW +: DW], e.data[p*DW +: DW], $time);
          end
          n_tests++;
          if (R_Busy[p] !== e.busy[p]) begin
            n_fail++;
            $display("FAIL rbusy port%0d addr %0d: got %b expected %b at %0t",
                     p, R_Addr[p*AW +: AW], R_Busy[p], e.busy[p], $time);
          end
        end
        n_tests++;
        if (Wr_Conflict !== e.conf) begin
          n_fail++;
          $display("FAIL wr_conflict: got %b expected %b at %0t", Wr_Conflict, e.conf, $time);
        end
      end
    end
  end

  task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [63:0] sval(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'h5A5A_0000 ^ 32'(i * 7)};
  endfunction

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    Reg_Write0 = 0; Reg_Write1 = 0; Issue_Valid = 0;
    W_Addr0 = '0; W_Addr1 = '0; W_Data0 = '0; W_Data1 = '0; Issue_Addr = '0; R_Addr = '0;
    s_we0 = 0; s_we1 = 0; s_iv = 0; s_a0 = '0; s_a1 = '0; s_ia = '0;
    s_d0 = '0; s_d1 = '0; s_raddr = '0;
    clear_model();

    // Reset held while a write is presented, then write/read back r5.
    step(1, 1, 5, 32'hFFFF_0000, 0, 0, 0, 1, 5, 5, 5);
    step(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 5, 5);
    idle(5, 5);
    step(1, 1, 6, 32'h1111_2222, 0, 0, 0, 0, 0, 5, 6);
    idle(5, 6);
    // Register 0: writes on both ports plus issue, all ignored.
    step(0, 1, 0, 32'h1234, 1, 0, 32'h1234, 1, 0, 0, 0);
    idle(0, 0);
    idle(0, 0);
    // Write clash on r7: port 1 wins, one-cycle conflict pulse.
    step(0, 1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 7);
    idle(7, 7);
    idle(7, 7);
    // Forwarding behaviour on r3 (busy first so masking is visible).
    step(0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 3);
    step(0, 1, 3, 32'hA5A5_A5A5, 0, 0, 0, 0, 0, 3, 3);
    idle(3, 3);
    // Scoreboard on r9.
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 9);
    idle(9, 9);
    step(0, 0, 0, 0, 1, 9, 32'h9999, 0, 0, 9, 9);
    idle(9, 9);
    step(0, 1, 9, 32'h9A9A, 0, 0, 0, 1, 9, 9, 9);
    idle(9, 9);
    idle(9, 9);

    // Random traffic over a small address window to provoke collisions.
    for (int n = 0; n < 300; n++) begin
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 11), $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 11), $urandom,
           $urandom_range(0, 2) == 0, $urandom_range(0, 11),
           $urandom_range(0, 11), $urandom_range(0, 11));
    end
    idle(1, 2);
    idle(1, 2);

    // Wide/shallow variant: r0 writable, eight distinct values over four ports.
    @(posedge clk_Regs); #1;
    s_we0 = 1; s_a0 = 3'd0; s_d0 = 64'h55;
    @(posedge clk_Regs); #1;
    s_we0 = 0; s_raddr = {3'd0, 3'd0, 3'd0, 3'd0};
    @(negedge clk_Regs);
    for (int p = 0; p < 4; p++) chk64($sformatf("sweep r0 port%0d", p), s_rdata[p*64 +: 64], 64'h55);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_Regs); #1;
      s_we0 = 1; s_a0 = 3'(2 * k);     s_d0 = sval(2 * k);
      s_we1 = 1; s_a1 = 3'(2 * k + 1); s_d1 = sval(2 * k + 1);
    end
    @(posedge clk_Regs); #1;
    s_we0 = 0; s_we1 = 0; s_raddr = {3'd3, 3'd2, 3'd1, 3'd0};
    @(negedge clk_Regs);
    for (int p = 0; p < 4; p++) chk64($sformatf("sweep r%0d", p), s_rdata[p*64 +: 64], sval(p));
    chk64("sweep busy", 64'(s_rbusy), 64'h0);
    #1;
    s_raddr = {3'd7, 3'd6, 3'd5, 3'd4};
    #1;
    for (int p = 0; p < 4; p++) chk64($sformatf("sweep r%0d", p + 4), s_rdata[p*64 +: 64], sval(p + 4));
    chk64("sweep conflict", 64'(s_conf), 64'h0);
    #1;
    s_raddr = {3'd6, 3'd6, 3'd6, 3'd6};
    #1;
    for (int p = 0; p < 4; p++) chk64($sformatf("sweep shared r6 port%0d", p), s_rdata[p*64 +: 64], sval(6));

    repeat (2) @(posedge clk_Regs);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
